// File: rtl/vendor_param.sv
// vendor_param: parametrised coin-operated vending controller.
// Accepts two coin denominations, dispenses one item per PRICE of credit and
// returns change serially as one-unit pulses. Optional refund-on-cancel support
// is compiled in when the VEND_CANCEL_EN macro is defined.
module vendor_param #(
    parameter int unsigned PRICE      = 3,
    parameter int unsigned COIN_A_VAL = 1,
    parameter int unsigned COIN_B_VAL = 2,
    parameter int unsigned CREDIT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_1,
    input  logic                coin_2,
    input  logic                cancel,
    output logic                dispense,
    output logic                change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] PriceW = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CoinAW = CREDIT_W'(COIN_A_VAL);
    localparam logic [CREDIT_W-1:0] CoinBW = CREDIT_W'(COIN_B_VAL);

`ifdef VEND_CANCEL_EN
    typedef enum logic [1:0] {StIdle, StVend, StChange, StRefund} state_e;
`else
    typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;
    // Port kept for pin compatibility; nothing consumes it in this build.
    logic unused_cancel;
    assign unused_cancel = cancel;
`endif

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] owed_q, owed_d;
    logic [CREDIT_W-1:0] sum;
    logic                coin_reject_q;

    // Credit after this cycle's coins; the width rule guarantees no wrap.
    always_comb begin
        sum = credit_q + (coin_1 ? CoinAW : '0) + (coin_2 ? CoinBW : '0);
    end

    // Next-state and register updates.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        owed_d   = owed_q;
        case (state_q)
            StIdle: begin
`ifdef VEND_CANCEL_EN
                // Cancel beats a completing coin: the whole sum goes back.
                if (cancel && (sum != '0)) begin
                    owed_d   = sum;
                    credit_d = '0;
                    state_d  = StRefund;
                end else
`endif
                if (sum >= PriceW) begin
                    owed_d   = sum - PriceW;
                    credit_d = '0;
                    state_d  = StVend;
                end else begin
                    credit_d = sum;
                end
            end
            StVend: begin
                state_d = (owed_q != '0) ? StChange : StIdle;
            end
            StChange: begin
                owed_d = owed_q - 1'b1;
                if (owed_q == CREDIT_W'(1)) state_d = StIdle;
            end
`ifdef VEND_CANCEL_EN
            StRefund: begin
                owed_d = owed_q - 1'b1;
                if (owed_q == CREDIT_W'(1)) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Moore output decodes of the registered state.
    always_comb begin
        dispense = (state_q == StVend);
`ifdef VEND_CANCEL_EN
        change   = (state_q == StChange) || (state_q == StRefund);
`else
        change   = (state_q == StChange);
`endif
        busy     = (state_q != StIdle);
        credit   = busy ? '0 : credit_q;
    end

    assign coin_reject = coin_reject_q;

    // State registers with synchronous active-low reset; busy-time coins are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            owed_q        <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            owed_q        <= owed_d;
            coin_reject_q <= busy && (coin_1 || coin_2);
        end
    end

endmodule

// File: doc/vendor_param.md
# vendor_param

Parametrised successor to the single-price `vendor` controller: accepts two coin denominations with configurable values and price, dispenses one item, and returns change serially as one-unit `change` pulses. It exposes running credit and a busy flag to the front-panel logic. It rejects coins presented while a vend or change return is in progress.

## Interface
Parameters:
- `PRICE`, 3, item price in credit units; must be ≥1.
- `COIN_A_VAL`, 1, credit value of `coin_1`; must be ≥1.
- `COIN_B_VAL`, 2, credit value of `coin_2`; must be ≥1.
- `CREDIT_W`, 4, credit/owed register width; must satisfy 2^CREDIT_W > PRICE−1+COIN_A_VAL+COIN_B_VAL.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `coin_1`  in  1  one-cycle pulse; each high cycle counts as one coin A.
- `coin_2`  in  1  one-cycle pulse; each high cycle counts as one coin B.
- `cancel`  in  1  refund request; only active with `VEND_CANCEL_EN`.
- `dispense`  out  1  one-cycle vend pulse.
- `change`  out  1  one pulse per unit of change or refund returned.
- `coin_reject`  out  1  one-cycle pulse for a coin presented while busy.
- `busy`  out  1  high whenever state ≠ IDLE.
- `credit`  out  CREDIT_W  accumulated credit; valid in IDLE, 0 otherwise.

## Operation
- States: IDLE, VEND, CHANGE, REFUND.
- Internal registers: `credit`, `owed`.

IDLE:
- Compute `sum = credit + (coin_1 ? COIN_A_VAL : 0) + (coin_2 ? COIN_B_VAL : 0)`. Simultaneous coins are both accepted.
- If `sum ≥ PRICE`: `owed <= sum − PRICE`, `credit <= 0`, go to VEND.
- Otherwise `credit <= sum`.

VEND:
- `dispense = 1`.
- If `owed ≠ 0`, go to CHANGE; otherwise go to IDLE.

CHANGE and REFUND:
- `change = 1` every cycle, and `owed <= owed − 1`.
- In the cycle where `owed == 1`, the next state is IDLE.
- REFUND never asserts `dispense`.

Coin rejection:
- Any `coin_1`/`coin_2` high while `busy` is discarded, leaving credit and owed unchanged.
- `coin_reject` is registered high the next cycle. Two rejected coins in the same cycle produce one reject pulse.

Outputs:
- `dispense`, `change` and `busy` are Moore decodes of registered state, so they are glitch-free.

Reset:
- Reset low at an edge forces state IDLE and clears credit, owed and all outputs, regardless of current state.
- Change still pending is discarded.

## Timing
- Reset values: `dispense`=0, `change`=0, `coin_reject`=0, `busy`=0, `credit`=0.
- A coin sampled at edge N updates `credit` after edge N.
- Completing coin at edge N:
  - `dispense` is high from edge N to N+1.
  - `credit` reads 0 after edge N.
- Change of k units: `change` is high for k consecutive cycles, starting at edge N+1.
- `busy` falls after the last `change` cycle, and a new coin is accepted in that same cycle.
- Total busy time per vend is 1+k cycles.
- Arithmetic is unsigned at CREDIT_W. Overflow cannot occur under the width rule.

## Configuration
- `VEND_CANCEL_EN` defined, in IDLE:
  - `cancel`=1 with `sum > 0`: `owed <= sum`, `credit <= 0`, go to REFUND.
  - Cancel wins over a completing coin in the same cycle, so `sum` is refunded and nothing is dispensed.
  - `cancel` with `sum = 0` is ignored.
  - `cancel` in any state other than IDLE is ignored.
- `VEND_CANCEL_EN` undefined:
  - The `cancel` port remains but is unused.
  - The REFUND state is not generated.

## Test plan
Defaults apply (PRICE=3, A=1, B=2).
- Three `coin_1` pulses, 2 cycles apart -> `credit` 1, 2; `dispense` high exactly one cycle after the third coin edge; zero `change` pulses; `credit`=0.
- `coin_2`, then `coin_2` -> `credit` 2; then `dispense` for 1 cycle, followed immediately by exactly 1 `change` pulse; `busy` for 2 cycles.
- `coin_1` and `coin_2` high in the same cycle -> `dispense` next cycle, no `change`.
- `coin_1` high during VEND -> `coin_reject` for 1 cycle; `credit` stays 0 after return to IDLE.
- With `VEND_CANCEL_EN`: `coin_2`, then `cancel` -> 2 `change` pulses, no `dispense`, `credit`=0. Without it: no response, `credit` stays 2.
- Price 7, `coin_2` ×4 (credit 8), then reset low during the first `change` cycle -> all outputs 0 after that edge; no further `change` pulses.
